// File: rtl/expr_pkg.sv
// Shared types for the expression arbiter: top FSM states, validator states,
// character classes and the byte classifier.
package expr_pkg;

    localparam logic [7:0] TERM_DEFAULT = 8'h3B;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        REPORT
    } arb_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        NUM,
        OP,
        BAD
    } chk_state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_OTHER,
        CLS_TERM
    } char_class_t;

    // The terminator is tested first so it always wins over the other classes.
    function automatic char_class_t classify(input logic [7:0] ch, input logic [7:0] term);
        char_class_t cls;
        if (ch == term) begin
            cls = CLS_TERM;
        end else if (ch >= 8'h30 && ch <= 8'h39) begin
            cls = CLS_DIGIT;
        end else if (ch == 8'h2B || ch == 8'h2A) begin
            cls = CLS_OP;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/expr_check.sv
// Expression validator FSM plus saturating character counter.
// Optional feature macro: EXPR_MULTIDIGIT_EN (multi-digit operands accepted).
//
// state | meaning
// EMPTY | nothing accepted yet in this frame
// NUM   | last character completed an operand
// OP    | last character was an operator, operand expected next
// BAD   | frame is malformed or too long; sticky until cleared
module expr_check
    import expr_pkg::*;
#(
    parameter int unsigned MAXLEN = 15,
    localparam int unsigned LW = $clog2(MAXLEN + 2)
)(
    input  logic          clk,
    input  logic          clr,
    input  logic          clear,
    input  logic          step,
    input  char_class_t   char_class,
    output chk_state_t    state,
    output logic [LW-1:0] length
);

    localparam logic [LW-1:0] LEN_SAT = LW'(MAXLEN + 1);

    chk_state_t    state_nxt;
    logic [LW-1:0] length_nxt;

    // Next validator state and length for one accepted non-terminator byte.
    always_comb begin
        length_nxt = (length == LEN_SAT) ? length : length + LW'(1);
        state_nxt  = state;
        case (state)
            EMPTY: state_nxt = (char_class == CLS_DIGIT) ? NUM : BAD;
            NUM: begin
                if (char_class == CLS_OP) begin
                    state_nxt = OP;
`ifdef EXPR_MULTIDIGIT_EN
                end else if (char_class == CLS_DIGIT) begin
                    state_nxt = NUM;
`endif
                end else begin
                    state_nxt = BAD;
                end
            end
            OP:      state_nxt = (char_class == CLS_DIGIT) ? NUM : BAD;
            default: state_nxt = BAD;
        endcase
        // An over-long frame can never be valid, whatever its content.
        if (length_nxt == LEN_SAT) begin
            state_nxt = BAD;
        end
    end

    // Validator and counter registers; cleared at the start of every grant.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= EMPTY;
            length <= '0;
        end else if (clear) begin
            state  <= EMPTY;
            length <= '0;
        end else if (step) begin
            state  <= state_nxt;
            length <= length_nxt;
        end
    end

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin sharing of one expression validator between two byte-stream
// requesters. A grant lasts for a whole frame; the verdict is a one-cycle
// strobe tagged with the requester ID.
// Optional feature macro: EXPR_MULTIDIGIT_EN (handled inside expr_check).
//
// state  | meaning
// IDLE   | no frame in progress, waiting for any requester
// FEED   | granted requester streams bytes into the validator
// REPORT | verdict strobe, last-served pointer updated
module expr_arbiter
    import expr_pkg::*;
#(
    parameter int unsigned MAXLEN = 15,
    parameter logic [7:0]  TERM   = TERM_DEFAULT,
    localparam int unsigned LW    = $clog2(MAXLEN + 2)
)(
    input  logic          clk,
    input  logic          clr,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    output logic          res_id,
    output logic          res_ok,
    output logic [LW-1:0] res_len
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          grant;
    logic          grant_nxt;
    logic          last;
    logic          last_nxt;

    logic          sel_valid;
    logic [7:0]    sel_data;
    char_class_t   sel_class;

    logic          clear;
    logic          step;
    logic          term_accept;

    chk_state_t    chk_state;
    logic [LW-1:0] chk_len;

    // Route the granted requester's byte to the classifier.
    always_comb begin
        sel_valid = grant ? req1_valid : req0_valid;
        sel_data  = grant ? req1_data  : req0_data;
        sel_class = classify(sel_data, TERM);
    end

    // Arbiter next state, grant decision and handshake outputs.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_nxt    = last;
        clear       = 1'b0;
        step        = 1'b0;
        term_accept = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    clear     = 1'b1;
                    state_nxt = FEED;
                    if (req0_valid && req1_valid) begin
                        grant_nxt = ~last;
                    end else begin
                        grant_nxt = req1_valid;
                    end
                end
            end
            FEED: begin
                req0_ready = ~grant;
                req1_ready = grant;
                if (sel_valid) begin
                    if (sel_class == CLS_TERM) begin
                        term_accept = 1'b1;
                        state_nxt   = REPORT;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            REPORT: begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state, current grant and last-served pointer.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Verdict registers: strobe pulses once, payload holds until the next frame ends.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_ok    <= 1'b0;
            res_len   <= '0;
        end else begin
            res_valid <= term_accept;
            if (term_accept) begin
                res_id  <= grant;
                res_ok  <= (chk_state == NUM);
                res_len <= chk_len;
            end
        end
    end

    expr_check #(
        .MAXLEN(MAXLEN)
    ) u_check (
        .clk       (clk),
        .clr       (clr),
        .clear     (clear),
        .step      (step),
        .char_class(sel_class),
        .state     (chk_state),
        .length    (chk_len)
    );

endmodule

// File: doc/expr_arbiter.md
# expr_arbiter

Shares one expression validator between two byte-stream requesters. Each requester sends a frame of ASCII characters ended by a terminator byte. The block grants the validator to one requester for a whole frame using round-robin arbitration, and feeds it one character per handshake. At the terminator it returns a one-cycle verdict tagged with the requester ID. It sits between the character sources and the result consumer in the expression-checking path.

## Interface
- MAXLEN, 15: maximum accepted characters per frame, terminator excluded.
- TERM, 8'h3B: terminator byte (';').
- LW, $clog2(MAXLEN+2): width of the length report (derived; do not override).
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  byte accepted when valid and ready are both high.
- req1_valid / req1_data / req1_ready: same as requester 0, for requester 1.
- res_valid  out  1  verdict strobe, one cycle.
- res_id  out  1  requester the verdict belongs to.
- res_ok  out  1  1 = the frame is a well-formed expression.
- res_len  out  LW  non-terminator characters accepted, saturating at MAXLEN+1.

## Operation
- Character classes:
  - DIGIT: '0'..'9'.
  - OP: '+' or '*'.
  - OTHER: every other byte except TERM.
- Top FSM has three states: IDLE, FEED, REPORT.
- IDLE:
  - If any reqN_valid is high, grant and go to FEED.
  - Grant goes to the requester not served last; if only one is valid, grant that one.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- FEED:
  - Only the granted reqN_ready is high.
  - Each accepted non-TERM byte advances the validator and the length counter.
  - An accepted TERM latches the verdict and goes to REPORT.
  - The non-granted requester is stalled until the frame ends.
- REPORT:
  - res_valid=1 with res_id, res_ok and res_len.
  - Update the last-served pointer, go to IDLE.
  - Both ready outputs are low in REPORT and IDLE.
- Validator FSM has four states: EMPTY, NUM, OP, BAD. It is cleared to EMPTY on grant.
  - EMPTY: DIGIT→NUM; anything else→BAD.
  - NUM: OP→OP; DIGIT→BAD (single-digit operands); OTHER→BAD.
  - OP: DIGIT→NUM; anything else→BAD.
  - BAD is sticky.
- Length rules:
  - Counter saturates at MAXLEN+1.
  - Reaching MAXLEN+1 forces BAD.
- Verdict: res_ok = (validator in NUM) at TERM acceptance.
  - An empty frame (TERM first) gives res_ok=0, res_len=0.
- The block never drops a byte: data is sampled only on a handshake.

## Timing
- Reset values: req0_ready=0, req1_ready=0, res_valid=0, res_id=0, res_ok=0, res_len=0. FSM in IDLE, validator in EMPTY, pointer=1.
- Reset mid-frame discards the partial frame; no verdict is emitted.
- Grant: request seen in IDLE at cycle N → ready high at N+1.
- Throughput in FEED: one byte per cycle.
- Verdict: TERM accepted at cycle T → res_valid at T+1.
  - The next grant can be in IDLE at T+2; next ready at T+3.
- res_* are registered and hold their values until the next REPORT. Only res_valid pulses.
- A requester dropping valid mid-frame only stalls FEED; the grant is held indefinitely.
- Both requesters rising valid in the same IDLE cycle: the round-robin rule decides.

## Configuration
- EXPR_MULTIDIGIT_EN defined: NUM on DIGIT stays in NUM, so "12+3;" is valid.
- Undefined: NUM on DIGIT→BAD, so "12+3;" gives res_ok=0.
- Nothing else changes: ports, latency and length rules are identical either way.

## Structure
- Package expr_pkg holds:
  - top FSM state enum (IDLE/FEED/REPORT);
  - validator state enum (EMPTY/NUM/OP/BAD);
  - character-class enum (CLS_DIGIT/CLS_OP/CLS_OTHER/CLS_TERM) with a classify function;
  - the TERM default constant.
- Sub-module expr_check is the validator FSM plus the saturating length counter.
  - Inputs: clk, clr, clear, step, class.
  - Outputs: state, length.
- The top holds the arbiter, handshake muxing and the result registers.

## Test plan
- Requester 0 sends "1+2*3;" back-to-back → res_valid one cycle after ';' with res_id=0, res_ok=1, res_len=5.
- Requester 1 sends "1++2;" → res_ok=0, res_len=4. Sending ";" alone → res_ok=0, res_len=0.
- Both valid from reset, each with "4;" → requester 0 served first, then 1, then 0. req1_ready stays 0 throughout requester 0's frame.
- 16 alternating characters then ';' with MAXLEN=15 → res_ok=0, res_len=16. "12+3;" → res_ok=1 with EXPR_MULTIDIGIT_EN, res_ok=0 without.
- clr pulsed low after "1+" of requester 1 → all outputs 0 and no res_valid. Requester 0 then sends "7;" → res_id=0, res_ok=1.
- Requester 0 deasserts valid for 3 cycles mid-frame while requester 1 is valid → grant held; the frame completes with the correct verdict; requester 1 is served next.
